pc_unit: RTL

Parametrised program-counter unit for the MIPS fetch stage, replacing the single-mode PC. It generates the instruction fetch address each cycle and implements MIPS delayed-branch semantics: one delay slot for PC-relative branches, region jumps and register jumps. It also provides stall hold, an exception vector redirect and a sticky misaligned-target flag. It sits between decode/control and instruction memory.

---
 rtl/pc_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter unit for the MIPS fetch stage. It produces the instruction
// fetch address every cycle and implements delayed-branch semantics: an
// accepted branch, region jump or register jump fetches the sequential delay
// slot first and then redirects to the resolved target.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   reset_n        in   synchronous active-low reset
//   stall          in   hold addr, pending redirect and target
//   branch_en      in   taken PC-relative branch for the instruction at addr
//   branch_offset  in   16-bit signed word offset
//   jump_en        in   J/JAL region jump
//   jump_index     in   26-bit word index
//   jr_en          in   JR/JALR register jump
//   jr_target      in   register-supplied target (WIDTH bits)
//   exception      in   redirect to EXC_VECTOR, overrides everything but reset
//   addr           out  current fetch address (registered)
//   in_delay_slot  out  addr is a delay-slot fetch; a redirect is pending
//   misaligned     out  sticky: a jr_target with nonzero bits [1:0] was taken
//
// Handshake: there is no valid/ready pair here. A request is accepted on a
// rising edge where reset_n=1, exception=0, stall=0 and no redirect is
// pending; requests in any other cycle are dropped, not queued.
// ---------------------------------------------------------------------------
module pc_unit #(
   parameter int          WIDTH        = 32,
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             branch_en,
   input  logic [15:0]      branch_offset,
   input  logic             jump_en,
   input  logic [25:0]      jump_index,
   input  logic             jr_en,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exception,
   output logic [WIDTH-1:0] addr,
   output logic             in_delay_slot,
   output logic             misaligned
);

   // ST_SEQ: sequential fetch, requests accepted.
   // ST_DELAY: the delay slot is being fetched, redirect to target pending.
   typedef enum logic {
      ST_SEQ   = 1'b0,
      ST_DELAY = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             misaligned_q, misaligned_d;

   logic [WIDTH-1:0] seq_addr;
   logic [WIDTH-1:0] branch_disp;
   logic [WIDTH-1:0] branch_tgt;
   logic [WIDTH-1:0] jump_tgt;
   logic [WIDTH-1:0] jr_tgt;

   // Sequential address; wraps modulo 2^WIDTH with no flag.
   assign seq_addr    = addr_q + WIDTH'(4);
   // Sign-extended word offset converted to a byte displacement.
   assign branch_disp = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
   assign branch_tgt  = seq_addr + branch_disp;
   // Region jump keeps the top four bits of the delay-slot address.
   assign jump_tgt    = {seq_addr[WIDTH-1:28], jump_index, 2'b00};
   // Register targets are forced word aligned; misalignment is only flagged.
   assign jr_tgt      = {jr_target[WIDTH-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_SEQ;
         addr_q       <= WIDTH'(RESET_VECTOR);
         target_q     <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         target_q     <= target_d;
         misaligned_q <= misaligned_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      target_d     = target_q;
      misaligned_d = misaligned_q;

      if (exception) begin
         // Overrides stall, requests and any pending redirect.
         addr_d  = WIDTH'(EXC_VECTOR);
         state_d = ST_SEQ;
      end else if (stall) begin
         // Everything holds; requests are dropped.
      end else begin
         case (state_q)
            ST_DELAY: begin
               // Requests presented in the delay slot are ignored.
               addr_d  = target_q;
               state_d = ST_SEQ;
            end
            default: begin
               addr_d = seq_addr;
               if (jr_en) begin
                  target_d = jr_tgt;
                  state_d  = ST_DELAY;
                  if (jr_target[1:0] != 2'b00) begin
                     misaligned_d = 1'b1;
                  end
               end else if (jump_en) begin
                  target_d = jump_tgt;
                  state_d  = ST_DELAY;
               end else if (branch_en) begin
                  target_d = branch_tgt;
                  state_d  = ST_DELAY;
               end
            end
         endcase
      end
   end

   assign addr          = addr_q;
   assign in_delay_slot = (state_q == ST_DELAY);
   assign misaligned    = misaligned_q;

endmodule
